// File: rtl/conv_output_collector_pkg.sv
// Shared definitions for the convolver output collector.
//   - default map geometry (N/K/S) and helpers deriving the output side M and
//     the buffer address width AW
//   - accumulator (33-bit) and activation (16-bit) widths
//   - collector FSM state type
package conv_pkg;

  localparam int N_DEF = 10;
  localparam int K_DEF = 3;
  localparam int S_DEF = 1;

  localparam int ACC_W = 33;
  localparam int ACT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WAIT_END,
    DONE
  } state_t;

  // Output map side for an NxN input, KxK kernel and stride S.
  function automatic int calc_m(input int n, input int k, input int s);
    return (n - k) / s + 1;
  endfunction

  // Address width covering M*M entries (at least one bit).
  function automatic int calc_aw(input int m);
    return (m * m > 1) ? $clog2(m * m) : 1;
  endfunction

endpackage

// File: rtl/conv_output_collector_if.sv
// Stream + read-port bundle between the convolver side / next layer (master)
// and the output collector (slave).
//   ce, start, conv_op, valid_conv, end_conv : capture stream and control
//   rd_en, rd_addr, rd_data, rd_valid         : registered read port
//   busy, done, sat_flag, err_short, err_long : status
interface conv_output_collector_if #(
  parameter int AW = 6
);
  import conv_pkg::*;

  logic             ce;
  logic             start;
  logic [ACC_W-1:0] conv_op;
  logic             valid_conv;
  logic             end_conv;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [ACT_W-1:0] rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             sat_flag;
  logic             err_short;
  logic             err_long;

  modport master (
    output ce, start, conv_op, valid_conv, end_conv, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done, sat_flag, err_short, err_long
  );

  modport slave (
    input  ce, start, conv_op, valid_conv, end_conv, rd_en, rd_addr,
    output rd_data, rd_valid, busy, done, sat_flag, err_short, err_long
  );

endinterface

// File: rtl/conv_output_collector_fm_buffer_ram.sv
// Output feature-map buffer: simple dual-port RAM, one write port and one
// registered read port. The array has no reset.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
module fm_buffer_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_output_collector.sv
// Consumer end of the convolver output stream. Captures conv_op when
// valid_conv & ce in COLLECT, rounds/saturates the Q16.16 sum to a Q8.8
// activation, and writes it one cycle later in raster order into an MxM
// buffer. After M*M captures and end_conv, the map is readable in DONE.
//   clk, global_rst_n : clock, asynchronous active-low reset
//   bus (slave)       : stream, control, read port and status
module conv_output_collector
  import conv_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int K          = K_DEF,
  parameter int S          = S_DEF,
  parameter int FRAC_SHIFT = 8
) (
  input logic                   clk,
  input logic                   global_rst_n,
  conv_output_collector_if.slave bus
);

  localparam int M  = calc_m(N, K, S);
  localparam int MM = M * M;
  localparam int AW = calc_aw(M);
  localparam int CW = AW + 1;      // counter must reach MM itself
  localparam int XW = ACC_W + 1;   // rounding headroom

  localparam logic signed [XW-1:0] RND_BIAS = XW'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [XW-1:0] SAT_MAX  = XW'((1 << (ACT_W - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN  = ~SAT_MAX;

  state_t           state_q, state_d;
  logic [CW-1:0]    wr_cnt_q;
  logic [ACC_W-1:0] cap_data_q;
  logic [AW-1:0]    cap_addr_q;
  logic             cap_vld_q;
  logic             sat_q, err_short_q, err_long_q;
  logic             rd_valid_q, rd_oor_q;
  logic [ACT_W-1:0] ram_q;

  logic capture, arm, late, early_end, rd_go, rd_in_range;

  assign capture     = (state_q == COLLECT) && bus.valid_conv && bus.ce;
  assign arm         = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign late        = ((state_q == WAIT_END) || (state_q == DONE)) &&
                       bus.valid_conv && bus.ce;
  // end_conv is a level that may still be high from the previous frame, so
  // it only counts once this frame has captured something.
  assign early_end   = (state_q == COLLECT) && bus.end_conv &&
                       (wr_cnt_q != '0) && (wr_cnt_q < CW'(MM));
  // start in the same DONE cycle takes priority and drops the read.
  assign rd_go       = (state_q == DONE) && bus.rd_en && !bus.start;
  assign rd_in_range = CW'(bus.rd_addr) < CW'(MM);

  // Round-half-up, arithmetic shift, clamp to the signed activation range.
  logic signed [XW-1:0] rnd_sum, rnd_shift;
  logic [ACT_W-1:0]     rnd_act;
  logic                 rnd_sat;

  always_comb begin
    rnd_sum   = $signed({cap_data_q[ACC_W-1], cap_data_q}) + RND_BIAS;
    rnd_shift = rnd_sum >>> FRAC_SHIFT;
    rnd_act   = rnd_shift[ACT_W-1:0];
    rnd_sat   = 1'b0;
    if (rnd_shift > SAT_MAX) begin
      rnd_act = SAT_MAX[ACT_W-1:0];
      rnd_sat = 1'b1;
    end else if (rnd_shift < SAT_MIN) begin
      rnd_act = SAT_MIN[ACT_W-1:0];
      rnd_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.start) state_d = COLLECT;
      COLLECT:  if (capture && (wr_cnt_q == CW'(MM - 1))) state_d = WAIT_END;
      // Leave only after the last captured sample has been written.
      WAIT_END: if (!cap_vld_q && bus.end_conv) state_d = DONE;
      DONE:     if (bus.start) state_d = COLLECT;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      wr_cnt_q    <= '0;
      cap_data_q  <= '0;
      cap_addr_q  <= '0;
      cap_vld_q   <= 1'b0;
      sat_q       <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_oor_q    <= 1'b0;
    end else begin
      cap_vld_q <= capture;
      if (capture) begin
        cap_data_q <= bus.conv_op;
        cap_addr_q <= wr_cnt_q[AW-1:0];
      end
      if (arm) begin
        wr_cnt_q    <= '0;
        sat_q       <= 1'b0;
        err_short_q <= 1'b0;
        err_long_q  <= 1'b0;
      end else begin
        if (capture)             wr_cnt_q    <= wr_cnt_q + CW'(1);
        if (cap_vld_q && rnd_sat) sat_q      <= 1'b1;
        if (early_end)           err_short_q <= 1'b1;
        if (late)                err_long_q  <= 1'b1;
      end
      rd_valid_q <= rd_go;
      rd_oor_q   <= rd_go && !rd_in_range;
    end
  end

  fm_buffer_ram #(
    .DEPTH (MM),
    .AW    (AW),
    .DW    (ACT_W)
  ) u_ram (
    .clk   (clk),
    .we    (cap_vld_q),
    .waddr (cap_addr_q),
    .wdata (rnd_act),
    .re    (rd_go && rd_in_range),
    .raddr (bus.rd_addr),
    .rdata (ram_q)
  );

  assign bus.rd_data   = (rd_valid_q && !rd_oor_q) ? ram_q : '0;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = (state_q == COLLECT) || (state_q == WAIT_END);
  assign bus.done      = (state_q == DONE);
  assign bus.sat_flag  = sat_q;
  assign bus.err_short = err_short_q;
  assign bus.err_long  = err_long_q;

endmodule

// File: doc/conv_output_collector.md
Name: conv_output_collector

Overview:
- Consumer end of the convolver output stream: captures each `conv_op` qualified by `valid_conv` and `ce`.
- Rounds and saturates each 33-bit accumulation to a signed 16-bit activation and writes it, in raster order, into an M×M output feature-map buffer.
- Signals frame completion and exposes a registered read port so the next layer can fetch the stored map.

Parameters:
- `N`, 10: input activation map size; must match the upstream convolver.
- `K`, 3: kernel size.
- `S`, 1: stride.
- `FRAC_SHIFT`, 8: right-shift applied to the Q16.16 accumulation to return to Q8.8; must be ≥1.
- `M`, derived as (N-K)/S+1: output map side; 8 at defaults.
- `AW`, derived as clog2(M*M): buffer address width; 6 at defaults.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `global_rst_n`, input, 1: asynchronous, active-low reset.
- `ce`, input, 1: same clock enable as the convolver; a capture happens only when `ce`=1.
- `start`, input, 1: single-cycle pulse that arms collection of a new frame.
- `conv_op`, input, 33: signed two's-complement convolution sum.
- `valid_conv`, input, 1: `conv_op` is a valid output sample this cycle.
- `end_conv`, input, 1: convolver end-of-frame level.
- `rd_en`, input, 1: read request.
- `rd_addr`, input, AW: read address (raster index row*M+col).
- `rd_data`, output, 16: stored activation.
- `rd_valid`, output, 1: `rd_data` is valid.
- `busy`, output, 1: high in COLLECT and WAIT_END.
- `done`, output, 1: frame complete; buffer is readable.
- `sat_flag`, output, 1: sticky; at least one sample saturated this frame.
- `err_short`, output, 1: sticky; `end_conv` seen before M*M samples were captured.
- `err_long`, output, 1: sticky; a valid sample arrived after M*M samples were captured.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `global_rst_n` is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; write counter 0; capture register cleared. Buffer RAM contents are not cleared (undefined).
- Reset asserted mid-frame aborts immediately, with no partial done.
- FSM has four states: IDLE, COLLECT, WAIT_END, DONE.
- IDLE:
  - `start` moves to COLLECT.
  - All `valid_conv` samples are ignored.
- COLLECT:
  - A capture occurs on each cycle with `valid_conv`&`ce`=1.
  - Capture at cycle t latches `conv_op`; the rounded/saturated value is written to `wr_cnt` at t+1. Write latency is 1 cycle.
  - `wr_cnt` increments at capture.
  - When capture number M*M-1 (0-based) occurs, the FSM moves to WAIT_END on the next edge.
- WAIT_END:
  - Waits for the final write to commit and for `end_conv`=1 (level, sampled).
  - Then moves to DONE.
  - Valid samples here are not written and set `err_long`.
- DONE:
  - `done`=1 and reads are enabled.
  - `start` moves to COLLECT, clearing `done`, `wr_cnt`, `sat_flag`, `err_short` and `err_long`.
  - Valid samples here are not written and set `err_long`.
- Early end of frame: `end_conv`=1 in COLLECT with `wr_cnt`<M*M sets `err_short`; the FSM keeps collecting.
  - Upstream `end_conv` stays high, so `err_short` is checked only while `wr_cnt`≠0 or after one capture has occurred. This avoids a false flag from a stale level.
- `start` while `busy` is ignored.
- Arithmetic:
  - Step 1: tmp = `conv_op` + 2^(FRAC_SHIFT-1), computed in 34 bits.
  - Step 2: shift tmp right arithmetically by FRAC_SHIFT.
  - Step 3: clamp to [-32768, 32767].
  - Clamping sets `sat_flag`.
- Read port:
  - In DONE, `rd_en`=1 at cycle t gives `rd_data`=mem[`rd_addr`] and `rd_valid`=1 at t+1.
  - Outside DONE, `rd_en` is ignored and `rd_valid`=0.
  - `rd_addr` ≥ M*M returns 0 with `rd_valid`=1.
  - `start` and `rd_en` in the same DONE cycle: `start` wins and the read is dropped.
- `ce`=0 freezes capture only; the FSM, reads and the `end_conv` check continue.

Decomposition:
- Shared package `conv_pkg` holds:
  - `N`/`K`/`S` defaults and the M and AW derivation functions;
  - the 33-bit accumulator width and the 16-bit activation width;
  - the state enum {IDLE, COLLECT, WAIT_END, DONE}.
- One sub-module, `fm_buffer_ram`: simple dual-port RAM, 16-bit by M*M, one write port, one registered read port, no reset on the array.
- Round/saturate is inline combinational logic.

Test Plan:
- Nominal frame: N=10, K=3, S=1, `start` then 64 valid samples with `conv_op`=i<<8. Requires read addr i to return i, `done`=1 after `end_conv`, and `sat_flag`, `err_short` and `err_long` all 0.
- Rounding:
  - `conv_op`=384 gives 2.
  - `conv_op`=-384 gives -1.
  - `conv_op`=127 gives 0.
  - `sat_flag` stays 0.
- Saturation: `conv_op`=0x0_0100_0000 gives 32767 with `sat_flag`=1; `conv_op`=-(2^24) gives -32768.
- Gaps in `ce`/`valid_conv`:
  - `valid_conv` high during `ce`=0 cycles causes no capture.
  - 64 qualified samples are still all stored in order.
- Protocol errors:
  - `end_conv` after 40 samples sets `err_short`=1.
  - A 65th sample in WAIT_END sets `err_long`=1 and mem[0] is unchanged.
- Reset and restart:
  - `global_rst_n` low at sample 30 asynchronously clears `busy`, `done` and the flags.
  - A subsequent `start` plus a full frame reaches `done`=1.
  - `start` with `rd_en` in DONE gives `rd_valid`=0 the next cycle.
